sa_tile_sequencer: RTL and testbench
====================================

# sa_tile_sequencer

Control FSM for one weight-stationary systolic-array tile of SA_ROWS x SA_COLS MAC PEs. It runs one tile operation per `start`:
- preloads a weight row per accepted beat;
- streams `cfg_num_vecs` activation vectors into the array with per-row skew;
- waits for the wavefront to drain, then pulses `done`.

It sits between the tile-level scheduler (configuration, start/done) and the PE grid. It drives the grid's shared `load_w`, `transpose_en` and per-row `valid_in` controls.

## Interface
- SA_ROWS, 4, PE rows; also the weight rows loaded and the activation skew depth
- SA_COLS, 4, PE columns; used for the drain length
- CNT_W, 16, width of the vector count and the performance counter
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a tile operation; sampled only in IDLE
- cfg_transpose  in  1  weight-transpose mode; captured on accepted `start`
- cfg_num_vecs  in  CNT_W  activation vectors to stream; captured on accepted `start`
- w_valid  in  1  weight row present on the array's weight inputs
- w_ready  out  1  sequencer accepts a weight row
- act_valid  in  1  activation vector present on the array's activation inputs
- act_ready  out  1  sequencer accepts an activation vector
- load_w  out  1  PE weight-load enable (all PEs)
- transpose_en  out  1  PE transpose select; held for the whole operation
- valid_in  out  SA_ROWS  per-row PE valid; bit r is bit 0 delayed r cycles
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at operation end
- stall_cnt  out  CNT_W  present only with the macro below

## Operation
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE:
  - On `start`, latch `cfg_transpose` and `cfg_num_vecs`, clear counters and go to LOAD_W.
  - `start` is ignored in every other state.
- LOAD_W:
  - `w_ready` = 1; `load_w` = `w_valid` & `w_ready`, combinational, in the same cycle as the data.
  - Count beats with `load_w`. After the SA_ROWS-th beat, go to COMPUTE.
  - If `cfg_num_vecs` == 0, go to DONE instead (no activations, no drain).
- COMPUTE:
  - `act_ready` = 1; `valid_in[0]` = `act_valid` & `act_ready`, combinational.
  - Count accepted vectors. On the `cfg_num_vecs`-th, go to DRAIN.
  - `act_valid` low inserts a bubble: `valid_in[0]` = 0 and the count holds.
- DRAIN:
  - Count exactly SA_ROWS+SA_COLS-1 cycles, then go to DONE.
  - The `valid_in[SA_ROWS-1:1]` skew shift register keeps shifting in DRAIN.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- The skew shift register shifts in all states with input `valid_in[0]`, so it empties naturally.
- `transpose_en` = latched `cfg_transpose` while `busy`; 0 in IDLE.
- Counters saturate-free. `cfg_num_vecs` up to 2^CNT_W-1 must be handled without wrap error.

## Timing
- Reset values:
  - state IDLE;
  - `w_ready`, `act_ready`, `load_w`, `transpose_en`, `busy`, `done`: 0;
  - `valid_in` all 0;
  - counters 0;
  - `stall_cnt` 0.
- `start` at edge N puts the FSM in LOAD_W from cycle N+1, so `w_ready` and `busy` are high in cycle N+1.
- `valid_in[r]` is high exactly r cycles after `valid_in[0]`.
- With `w_valid` and `act_valid` held high, minimum cycles from `start` to `done` = 1 + SA_ROWS + cfg_num_vecs + (SA_ROWS+SA_COLS-1).
- `rst` asserted in any state takes effect next edge: all outputs return to reset values, and the skew register and in-flight operation are discarded.
- `w_ready` and `act_ready` are never high in the same cycle.

## Configuration
- `SA_SEQ_PERF_CNT_EN` defined:
  - adds output `stall_cnt`;
  - counts COMPUTE cycles with `act_valid` == 0 and LOAD_W cycles with `w_valid` == 0;
  - cleared on accepted `start` and on `rst`;
  - holds its value after `done` until the next `start`.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Reset mid-COMPUTE (SA 4x4, `cfg_num_vecs`=8, `rst` after 3 vectors):
  - next cycle `busy`=0 and `valid_in`=0000;
  - a following `start` runs a full clean operation.
- Nominal (4x4, `cfg_num_vecs`=5, `w_valid`/`act_valid` held high):
  - 4 `load_w` cycles, then 5 cycles of `valid_in[0]`;
  - `valid_in[3]` high 3 cycles later;
  - `done` exactly 1+4+5+7 = 17 cycles after `start`.
- Bubbles: deassert `act_valid` for 2 cycles mid-stream:
  - `valid_in[0]` shows the gap and each row repeats it shifted;
  - `done` is 2 cycles later than nominal;
  - `stall_cnt`=2 when the macro is on.
- Zero vectors (`cfg_num_vecs`=0):
  - 4 `load_w` beats, then `done` the next cycle;
  - `act_ready` never high.
- Transpose and start-while-busy:
  - `cfg_transpose`=1: `transpose_en`=1 for the whole busy window, and toggling `cfg_transpose` mid-op has no effect;
  - `start` pulses while busy are ignored, giving exactly one `done`.

Source files
------------

// File: rtl/sa_tile_sequencer.sv
// Control sequencer for one weight-stationary systolic-array tile: weight preload, skewed activation
// streaming, wavefront drain and done pulse. Optional stall counter enabled by SA_SEQ_PERF_CNT_EN.
module sa_tile_sequencer #(
  parameter int SA_ROWS = 4,
  parameter int SA_COLS = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               cfg_transpose_i,
  input  logic [CNT_W-1:0]   cfg_num_vecs_i,
  input  logic               w_valid_i,
  output logic               w_ready_o,
  input  logic               act_valid_i,
  output logic               act_ready_o,
  output logic               load_w_o,
  output logic               transpose_en_o,
  output logic [SA_ROWS-1:0] valid_in_o,
  output logic               busy_o,
  output logic               done_o
`ifdef SA_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o
`endif
);

  localparam int DRAIN_LEN = SA_ROWS + SA_COLS - 1;
  localparam logic [CNT_W-1:0] LAST_W     = CNT_W'(SA_ROWS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_vecs_q;
  logic               transpose_q;
  logic               capture;
  logic               valid0;
  logic [SA_ROWS-1:1] skew_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Configuration is only observed while busy, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      num_vecs_q  <= cfg_num_vecs_i;
      transpose_q <= cfg_transpose_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    w_ready_o   = 1'b0;
    act_ready_o = 1'b0;
    load_w_o    = 1'b0;
    valid0      = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        w_ready_o = 1'b1;
        load_w_o  = w_valid_i;
        if (load_w_o) begin
          if (cnt_q == LAST_W) begin
            cnt_d   = '0;
            state_d = (num_vecs_q == '0) ? S_DONE : S_COMPUTE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        act_ready_o = 1'b1;
        valid0      = act_valid_i;
        // Compare against N-1 so a full-scale count never needs an extra bit.
        if (valid0) begin
          if (cnt_q == num_vecs_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Row r sees row 0's valid delayed r cycles; shifting never stops so it drains itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skew_q <= '0;
    end else begin
      skew_q[1] <= valid0;
      for (int r = 2; r < SA_ROWS; r++) begin
        skew_q[r] <= skew_q[r-1];
      end
    end
  end

  assign valid_in_o     = {skew_q, valid0};
  assign transpose_en_o = busy_o & transpose_q;

`ifdef SA_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (capture) begin
      stall_q <= '0;
    end else if ((state_q == S_LOAD_W && !w_valid_i) ||
                 (state_q == S_COMPUTE && !act_valid_i)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Bench for sa_tile_sequencer: directed table, reset/boundary sequences and randomized operations
// checked cycle by cycle against a timeline model built from event times.
module tb_sa_tile_sequencer;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int CW = 16;
  localparam int DL = R + C - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          cfg_transpose_i;
  logic [CW-1:0] cfg_num_vecs_i;
  logic          w_valid_i;
  logic          w_ready_o;
  logic          act_valid_i;
  logic          act_ready_o;
  logic          load_w_o;
  logic          transpose_en_o;
  logic [R-1:0]  valid_in_o;
  logic          busy_o;
  logic          done_o;
`ifdef SA_SEQ_PERF_CNT_EN
  logic [CW-1:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  sa_tile_sequencer #(.SA_ROWS(R), .SA_COLS(C), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start_i),
    .cfg_transpose_i(cfg_transpose_i),
    .cfg_num_vecs_i (cfg_num_vecs_i),
    .w_valid_i      (w_valid_i),
    .w_ready_o      (w_ready_o),
    .act_valid_i    (act_valid_i),
    .act_ready_o    (act_ready_o),
    .load_w_o       (load_w_o),
    .transpose_en_o (transpose_en_o),
    .valid_in_o     (valid_in_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  bit wv [256];
  bit av [256];
  bit st [256];

  typedef struct {
    int n;
    bit tr;
    int bub_at;
    int bub_len;
    int exp_done;
    int exp_stall;
  } vec_t;

  function automatic logic [9:0] outs();
    return {w_ready_o, act_ready_o, load_w_o, transpose_en_o, busy_o, done_o, valid_in_o};
  endfunction

  task automatic check(input string nm, input int t, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, t, got, exp);
    end
  endtask

  // Model: loads are the first R cycles with w_valid, vectors the next n cycles with act_valid,
  // done lands DL+1 cycles after the last vector (or right after the last load when n is 0).
  task automatic run_op(input int n, input bit tr, output int done_obs, output int stall_obs);
    int cnt, t, tl, ta, td, stl;
    bit v0 [256];
    bit inL, inC, busyE;
    logic [R-1:0] ev;
    logic [9:0] e;
    cnt = 0; t = 0;
    while (cnt < R) begin t++; if (wv[t]) cnt++; end
    tl = t;
    cnt = 0;
    while (cnt < n) begin t++; if (av[t]) cnt++; end
    ta = t;
    td = (n == 0) ? tl + 1 : ta + DL + 1;
    for (int s = 0; s < 256; s++) v0[s] = (n > 0) && (s > tl) && (s <= ta) && av[s];
    stl = 0; done_obs = -1; stall_obs = 0;
    for (t = 0; t <= td + 2; t++) begin
      @(posedge clk); #1;
      start_i         = (t == 0) ? 1'b1 : ((t <= td) ? st[t] : 1'b0);
      cfg_transpose_i = (t == 0) ? tr : 1'($urandom);
      cfg_num_vecs_i  = (t == 0) ? CW'(n) : CW'($urandom);
      w_valid_i       = wv[t];
      act_valid_i     = av[t];
      @(negedge clk);
      inL   = (t >= 1) && (t <= tl);
      inC   = (n > 0) && (t > tl) && (t <= ta);
      busyE = (t >= 1) && (t <= td);
      for (int r = 0; r < R; r++) ev[r] = (t >= r) ? v0[t-r] : 1'b0;
      e = {inL, inC, inL && wv[t], busyE && tr, busyE, t == td, ev};
      check("outputs", t, 32'(outs()), 32'(e));
`ifdef SA_SEQ_PERF_CNT_EN
      if (t >= 1) check("stall_cnt", t, 32'(stall_cnt_o), 32'(stl));
      stall_obs = int'(stall_cnt_o);
`endif
      if ((inL && !wv[t]) || (inC && !av[t])) stl++;
      if (done_o && done_obs < 0) done_obs = t;
    end
    start_i = 1'b0;
  endtask

  initial begin
    vec_t tbl [6];
    int d, s, nv;
    tbl[0] = '{n: 5, tr: 1'b0, bub_at: 0, bub_len: 0, exp_done: 17, exp_stall: 0};
    tbl[1] = '{n: 5, tr: 1'b1, bub_at: 2, bub_len: 2, exp_done: 19, exp_stall: 2};
    tbl[2] = '{n: 0, tr: 1'b0, bub_at: 0, bub_len: 0, exp_done: 5,  exp_stall: 0};
    tbl[3] = '{n: 1, tr: 1'b1, bub_at: 0, bub_len: 0, exp_done: 13, exp_stall: 0};
    tbl[4] = '{n: 8, tr: 1'b0, bub_at: 3, bub_len: 3, exp_done: 23, exp_stall: 3};
    tbl[5] = '{n: 3, tr: 1'b1, bub_at: 0, bub_len: 1, exp_done: 16, exp_stall: 1};

    rst = 1'b1; start_i = 1'b0; cfg_transpose_i = 1'b0; cfg_num_vecs_i = '0;
    w_valid_i = 1'b0; act_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 0, 32'(outs()), 32'd0);
`ifdef SA_SEQ_PERF_CNT_EN
    check("reset_stall", 0, 32'(stall_cnt_o), 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // Reset mid-COMPUTE after three vectors.
    @(posedge clk); #1;
    start_i = 1'b1; cfg_num_vecs_i = 16'd8; cfg_transpose_i = 1'b1;
    w_valid_i = 1'b1; act_valid_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1; act_valid_i = 1'b0;
    @(negedge clk);
    check("pre_reset_compute", 8, 32'(outs()), 32'(10'b0_1_0_1_1_0_1110));
    @(posedge clk); #1 rst = 1'b0; act_valid_i = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", 9, 32'(outs()), 32'd0);
`ifdef SA_SEQ_PERF_CNT_EN
    check("post_reset_stall", 9, 32'(stall_cnt_o), 32'd0);
`endif

    foreach (tbl[k]) begin
      for (int t = 0; t < 256; t++) begin
        wv[t] = 1'b1;
        av[t] = !((t >= R + 1 + tbl[k].bub_at) && (t < R + 1 + tbl[k].bub_at + tbl[k].bub_len));
        st[t] = (t % 3 == 1);
      end
      run_op(tbl[k].n, tbl[k].tr, d, s);
      check("table_done_cycle", k, 32'(d), 32'(tbl[k].exp_done));
`ifdef SA_SEQ_PERF_CNT_EN
      check("table_stall", k, 32'(s), 32'(tbl[k].exp_stall));
`endif
    end

    for (int k = 0; k < 30; k++) begin
      for (int t = 0; t < 256; t++) begin
        wv[t] = (t >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
        av[t] = (t >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
        st[t] = ($urandom_range(0, 4) == 0);
      end
      run_op($urandom_range(0, 12), 1'($urandom_range(0, 1)), d, s);
    end

    // Full-scale vector count must not wrap.
    @(posedge clk); #1;
    start_i = 1'b1; cfg_num_vecs_i = 16'hFFFF; cfg_transpose_i = 1'b0;
    w_valid_i = 1'b1; act_valid_i = 1'b1;
    d = -1; nv = 0;
    for (int t = 1; t < 70000 && d < 0; t++) begin
      @(posedge clk); #1 start_i = 1'b0;
      @(negedge clk);
      if (valid_in_o[0]) nv++;
      if (done_o) d = t;
    end
    check("fullscale_done_cycle", 0, 32'(d), 32'd65547);
    check("fullscale_vectors", 0, 32'(nv), 32'd65535);
`ifdef SA_SEQ_PERF_CNT_EN
    check("fullscale_stall", 0, 32'(stall_cnt_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
